// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader.
// Packs a valid/ready byte stream into big-endian 32-bit words, writes each word to the
// next word address, and keeps the processor halted until the terminator word is stored.
module imem_loader #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter logic [31:0] TERMINATOR  = 32'hFFFF_FFFF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_write,
    output logic        cpu_halt,
    output logic        load_done,
    output logic        overflow_err,
    output logic [15:0] word_count
);

    localparam int unsigned CNT_W = 16;
    localparam logic [CNT_W:0] DEPTH_CNT = (CNT_W+1)'(DEPTH_WORDS);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RECV  = 3'd1,
        WRITE = 3'd2,
        DONE  = 3'd3,
        ERROR = 3'd4
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [1:0]         byte_idx;
    logic [1:0]         byte_idx_nxt;
    logic [31:0]        asm_word;
    logic [31:0]        asm_word_nxt;
    logic [31:0]        mem_addr_nxt;
    logic [31:0]        mem_wdata_nxt;
    logic               mem_write_nxt;
    logic               cpu_halt_nxt;
    logic               load_done_nxt;
    logic               overflow_err_nxt;
    logic [CNT_W-1:0]   word_count_nxt;
    logic               handshake;
    logic               is_term;
    logic               last_slot;

    // Ready is the only combinational output; a byte moves when both sides agree.
    assign byte_ready = (state == RECV);
    assign handshake  = byte_valid && byte_ready;
    assign is_term    = (asm_word == TERMINATOR);
    // True when the word being written now fills the last memory slot.
    assign last_slot  = ((CNT_W+1)'(word_count) + (CNT_W+1)'(1)) == DEPTH_CNT;

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state selection.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE, ERROR: begin
                if (start) state_nxt = RECV;
            end
            RECV: begin
                if (handshake && (byte_idx == 2'd3)) state_nxt = WRITE;
            end
            WRITE: begin
                if (is_term)        state_nxt = DONE;
                else if (last_slot) state_nxt = ERROR;
                else                state_nxt = RECV;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Next values for the registered outputs and datapath.
    always_comb begin
        byte_idx_nxt     = byte_idx;
        asm_word_nxt     = asm_word;
        mem_addr_nxt     = mem_addr;
        mem_wdata_nxt    = mem_wdata;
        mem_write_nxt    = 1'b0;
        cpu_halt_nxt     = cpu_halt;
        load_done_nxt    = load_done;
        overflow_err_nxt = overflow_err;
        word_count_nxt   = word_count;
        case (state)
            IDLE, DONE, ERROR: begin
                if (start) begin
                    byte_idx_nxt     = 2'd0;
                    mem_addr_nxt     = BASE_ADDR;
                    cpu_halt_nxt     = 1'b1;
                    load_done_nxt    = 1'b0;
                    overflow_err_nxt = 1'b0;
                    word_count_nxt   = '0;
                end
            end
            RECV: begin
                if (handshake) begin
                    asm_word_nxt = {asm_word[23:0], byte_in};
                    byte_idx_nxt = byte_idx + 2'd1;
                    // Strobe is registered so it lines up with the WRITE state.
                    if (byte_idx == 2'd3) begin
                        mem_write_nxt = 1'b1;
                        mem_wdata_nxt = {asm_word[23:0], byte_in};
                    end
                end
            end
            WRITE: begin
                mem_addr_nxt   = mem_addr + 32'd4;
                word_count_nxt = word_count + CNT_W'(1);
                if (is_term) begin
                    cpu_halt_nxt  = 1'b0;
                    load_done_nxt = 1'b1;
                end else if (last_slot) begin
                    overflow_err_nxt = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            byte_idx     <= 2'd0;
            asm_word     <= '0;
            mem_addr     <= BASE_ADDR;
            mem_wdata    <= '0;
            mem_write    <= 1'b0;
            cpu_halt     <= 1'b1;
            load_done    <= 1'b0;
            overflow_err <= 1'b0;
            word_count   <= '0;
        end else begin
            byte_idx     <= byte_idx_nxt;
            asm_word     <= asm_word_nxt;
            mem_addr     <= mem_addr_nxt;
            mem_wdata    <= mem_wdata_nxt;
            mem_write    <= mem_write_nxt;
            cpu_halt     <= cpu_halt_nxt;
            load_done    <= load_done_nxt;
            overflow_err <= overflow_err_nxt;
            word_count   <= word_count_nxt;
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader: a load-level reference model fills a write scoreboard,
// and a negedge monitor pops and compares every memory write the loader issues.
module tb_imem_loader;

    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] BASE  = 32'h0000_0000;
    localparam logic [31:0] TERM  = 32'hFFFF_FFFF;

    logic        clock;
    logic        reset;
    logic        start;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_write;
    logic        cpu_halt;
    logic        load_done;
    logic        overflow_err;
    logic [15:0] word_count;

    int          checks;
    int          errors;
    logic [63:0] exp_q[$];
    logic [7:0]  stream[$];

    imem_loader #(
        .DEPTH_WORDS (DEPTH),
        .BASE_ADDR   (BASE),
        .TERMINATOR  (TERM)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .byte_in      (byte_in),
        .byte_valid   (byte_valid),
        .byte_ready   (byte_ready),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_write    (mem_write),
        .cpu_halt     (cpu_halt),
        .load_done    (load_done),
        .overflow_err (overflow_err),
        .word_count   (word_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Write monitor: every strobe must match the oldest expected write.
    always @(negedge clock) begin
        if (mem_write === 1'b1) begin
            chk("ready_in_write", 32'(byte_ready), 32'd0);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr 0x%08h data 0x%08h, expected no write",
                         mem_addr, mem_wdata);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                chk("write_addr", mem_addr, e[63:32]);
                chk("write_data", mem_wdata, e[31:0]);
            end
        end
    end

    task automatic add_word(input logic [31:0] w);
        stream.push_back(w[31:24]);
        stream.push_back(w[23:16]);
        stream.push_back(w[15:8]);
        stream.push_back(w[7:0]);
    endtask

    // Present one byte from a negedge and hold it until the loader takes it.
    task automatic send_byte(input logic [7:0] b, input bit poke_start);
        int n;
        n = 0;
        byte_in    = b;
        byte_valid = 1'b1;
        while (byte_ready !== 1'b1 && n < 20) begin
            @(negedge clock);
            n++;
        end
        if (byte_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL handshake_timeout: got byte_ready=%b, expected 1 within 20 cycles", byte_ready);
        end
        if (poke_start) start = 1'b1;
        @(negedge clock);
        start      = 1'b0;
        byte_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        chk("start_halt",  32'(cpu_halt),     32'd1);
        chk("start_done",  32'(load_done),    32'd0);
        chk("start_ovf",   32'(overflow_err), 32'd0);
        chk("start_count", 32'(word_count),   32'd0);
        chk("start_ready", 32'(byte_ready),   32'd1);
    endtask

    // mode 0: back-to-back, 1: valid toggles 1/0, 2: random gaps.
    task automatic run_load(input int mode, input bit noise);
        int nwords;
        int consumed;
        int status;
        logic [31:0] w;
        nwords   = 0;
        consumed = 0;
        status   = 0;
        // Reference: whole words in order, stop after terminator or full memory.
        for (int i = 0; i + 3 < stream.size() && status == 0; i += 4) begin
            w = {stream[i], stream[i+1], stream[i+2], stream[i+3]};
            exp_q.push_back({BASE + 32'(4 * nwords), w});
            nwords++;
            consumed += 4;
            if (w == TERM)            status = 1;
            else if (nwords == DEPTH) status = 2;
        end
        pulse_start();
        for (int i = 0; i < consumed; i++) begin
            if ((mode == 1 && i > 0) || (mode == 2 && $urandom_range(0, 2) == 0)) begin
                byte_valid = 1'b0;
                byte_in    = 8'($urandom);
                @(negedge clock);
            end
            send_byte(stream[i], noise && ($urandom_range(0, 5) == 0));
        end
        chk("lat_write", 32'(mem_write), 32'd1);
        chk("lat_halt",  32'(cpu_halt),  32'd1);
        chk("lat_done",  32'(load_done), 32'd0);
        @(negedge clock);
        chk("end_halt",  32'(cpu_halt),     32'(status == 2));
        chk("end_done",  32'(load_done),    32'(status == 1));
        chk("end_ovf",   32'(overflow_err), 32'(status == 2));
        chk("end_count", 32'(word_count),   32'(nwords));
        chk("end_addr",  mem_addr,          BASE + 32'(4 * nwords));
        chk("end_ready", 32'(byte_ready),   32'd0);
        if (status == 2) begin
            byte_valid = 1'b1;
            for (int k = 0; k < 4; k++) begin
                byte_in = 8'($urandom);
                @(negedge clock);
                chk("ovf_ready", 32'(byte_ready), 32'd0);
                chk("ovf_count", 32'(word_count), 32'(nwords));
            end
            byte_valid = 1'b0;
        end
        stream.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1);
    end

    initial begin
        checks     = 0;
        errors     = 0;
        reset      = 1'b1;
        start      = 1'b1;
        byte_in    = 8'h00;
        byte_valid = 1'b0;
        // Reset held two cycles, with a coincident start that must lose.
        repeat (2) @(negedge clock);
        reset = 1'b0;
        start = 1'b0;
        chk("rst_halt",  32'(cpu_halt),     32'd1);
        chk("rst_write", 32'(mem_write),    32'd0);
        chk("rst_done",  32'(load_done),    32'd0);
        chk("rst_ovf",   32'(overflow_err), 32'd0);
        chk("rst_ready", 32'(byte_ready),   32'd0);
        chk("rst_count", 32'(word_count),   32'd0);
        chk("rst_addr",  mem_addr,          32'd0);
        @(negedge clock);
        chk("idle_ready", 32'(byte_ready), 32'd0);

        // Two-word program, back-to-back then with toggling valid.
        add_word(32'h2008_0005);
        add_word(TERM);
        run_load(0, 1'b0);
        add_word(32'h2008_0005);
        add_word(TERM);
        run_load(1, 1'b0);

        // Memory fills without terminator.
        for (int i = 1; i <= 4; i++) add_word(32'(i));
        run_load(0, 1'b0);

        // Reset mid-word discards the partial word.
        pulse_start();
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("midrst_halt",  32'(cpu_halt),   32'd1);
        chk("midrst_ready", 32'(byte_ready), 32'd0);
        chk("midrst_count", 32'(word_count), 32'd0);
        chk("midrst_write", 32'(mem_write),  32'd0);
        chk("midrst_addr",  mem_addr,        32'd0);
        add_word(32'h1122_3344);
        add_word(TERM);
        run_load(0, 1'b0);

        // Terminator landing in the final slot completes normally.
        for (int i = 0; i < 3; i++) add_word(32'($urandom_range(0, 1000)));
        add_word(TERM);
        run_load(2, 1'b0);

        // Random programs, gaps and stray starts during reception.
        for (int n = 0; n < 20; n++) begin
            int nw;
            nw = $urandom_range(1, 6);
            for (int k = 0; k < nw; k++) begin
                if ($urandom_range(0, 4) == 0) add_word(TERM);
                else                           add_word($urandom);
            end
            add_word(TERM);
            run_load(int'($urandom_range(0, 2)), 1'b1);
        end

        repeat (3) @(negedge clock);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
